// File: rtl/an_decode_ctrl_n37.sv
// an_decode_ctrl_n37: multi-cycle AN-code (A=37) decoder/corrector.
// Sequence: Barrett quotient, residue, residue fix-up, single-bit
// correction via a 37-entry adjust ROM, then a ready/valid output hold.
// Optional build macro: AN_ERR_CNT_EN adds saturating corr_cnt/fail_cnt.
`timescale 1ns/1ps

module an_decode_ctrl_n37 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [18:0] in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_msg,
    output logic        out_err,
    output logic        out_uncorr
`ifdef AN_ERR_CNT_EN
    ,
    output logic [15:0] corr_cnt,
    output logic [15:0] fail_cnt
`endif
);

    // Code constants; the adjust ROM below is derived for A=37 only.
    localparam int          A     = 37;
    localparam int          SHIFT = 24;
    localparam logic [37:0] MU    = 38'd453438;   // floor(2^24/37)

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_RED, S_FIX, S_COR, S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [18:0]         x_q, x_d;
    logic [13:0]         q_q, q_d;
    logic [19:0]         r_q, r_d;
    logic                out_valid_q, out_valid_d;
    logic [12:0]         out_msg_q, out_msg_d;
    logic                out_err_q, out_err_d;
    logic                out_uncorr_q, out_uncorr_d;
    logic signed [14:0]  adj;
    logic signed [14:0]  m;

    // Residue -> signed message adjustment. Residue 2^i mod 37 means bit i
    // was set by the error (subtract floor(2^i/37)); 37-(2^i mod 37) means
    // bit i was cleared (add ceil(2^i/37)). Since 2 is a primitive root
    // mod 37, the 36 nonzero residues are covered exactly once.
    function automatic logic signed [14:0] adj_rom(input logic [5:0] r);
        case (r)
            6'd3:    adj_rom =  15'sd7;
            6'd5:    adj_rom =  15'sd1;
            6'd6:    adj_rom =  15'sd14;
            6'd7:    adj_rom =  15'sd443;
            6'd9:    adj_rom = -15'sd1771;
            6'd10:   adj_rom =  15'sd2;
            6'd11:   adj_rom =  15'sd111;
            6'd12:   adj_rom =  15'sd28;
            6'd13:   adj_rom = -15'sd55;
            6'd14:   adj_rom =  15'sd886;
            6'd15:   adj_rom = -15'sd221;
            6'd17:   adj_rom = -15'sd3;
            6'd18:   adj_rom = -15'sd3542;
            6'd19:   adj_rom =  15'sd3543;
            6'd20:   adj_rom =  15'sd4;
            6'd21:   adj_rom =  15'sd1;
            6'd22:   adj_rom =  15'sd222;
            6'd23:   adj_rom = -15'sd885;
            6'd24:   adj_rom =  15'sd56;
            6'd25:   adj_rom = -15'sd27;
            6'd26:   adj_rom = -15'sd110;
            6'd27:   adj_rom = -15'sd1;
            6'd28:   adj_rom =  15'sd1772;
            6'd29:   adj_rom =  15'sd1;
            6'd30:   adj_rom = -15'sd442;
            6'd31:   adj_rom = -15'sd13;
            6'd33:   adj_rom =  15'sd1;
            6'd34:   adj_rom = -15'sd6;
            6'd35:   adj_rom =  15'sd1;
            6'd36:   adj_rom =  15'sd1;
            // 0, 1, 2, 4, 8, 16, 32 (low-bit errors) and unused codes.
            default: adj_rom =  15'sd0;
        endcase
    endfunction

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_msg    = out_msg_q;
    assign out_err    = out_err_q;
    assign out_uncorr = out_uncorr_q;

    // Next-state and datapath step for each sequencer state.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        x_d          = x_q;
        q_d          = q_q;
        r_d          = r_q;
        out_valid_d  = out_valid_q;
        out_msg_d    = out_msg_q;
        out_err_d    = out_err_q;
        out_uncorr_d = out_uncorr_q;
        adj          = '0;
        m            = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_code;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                q_d     = 14'((38'(x_q) * MU) >> SHIFT);
                state_d = S_RED;
            end
            S_RED: begin
                r_d     = {1'b0, x_q} - 20'(q_q) * 20'(A);
                state_d = S_FIX;
            end
            S_FIX: begin
                // Barrett underestimates q by at most one for 19-bit x.
                if (r_q >= 20'(A)) begin
                    r_d = r_q - 20'(A);
                    q_d = q_q + 14'd1;
                end
                state_d = S_COR;
            end
            S_COR: begin
                adj       = adj_rom(r_q[5:0]);
                // q+adj can exceed 16383 and wrap negative in 15 bits; both
                // the wrapped and unwrapped values land in the reject range.
                m         = $signed({1'b0, q_q}) + adj;
                out_err_d = (r_q != 20'd0);
                if (m < 15'sd0 || m > 15'sd8191) begin
                    out_uncorr_d = 1'b1;
                    out_msg_d    = '0;
                end else begin
                    out_uncorr_d = 1'b0;
                    out_msg_d    = m[12:0];
                end
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            q_q          <= '0;
            r_q          <= '0;
            out_valid_q  <= 1'b0;
            out_msg_q    <= '0;
            out_err_q    <= 1'b0;
            out_uncorr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            q_q          <= q_d;
            r_q          <= r_d;
            out_valid_q  <= out_valid_d;
            out_msg_q    <= out_msg_d;
            out_err_q    <= out_err_d;
            out_uncorr_q <= out_uncorr_d;
        end
    end

`ifdef AN_ERR_CNT_EN
    logic [15:0] corr_cnt_q, corr_cnt_d;
    logic [15:0] fail_cnt_q, fail_cnt_d;

    // Saturating event counters, stepped only on the output handshake.
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (out_valid_q && out_ready) begin
            if (out_uncorr_q) begin
                if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
            end else if (out_err_q) begin
                if (corr_cnt_q != 16'hFFFF) corr_cnt_d = corr_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            corr_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            corr_cnt_q <= corr_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign corr_cnt = corr_cnt_q;
    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_an_decode_ctrl_n37.sv
// tb_an_decode_ctrl_n37: directed and randomized bench for an_decode_ctrl_n37
// with a behavioural reference model (integer divide/modulo plus a search
// over single-bit error residues) and a per-cycle compare process.
`timescale 1ns/1ps

module tb_an_decode_ctrl_n37;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [18:0] in_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [12:0] out_msg;
    logic        out_err;
    logic        out_uncorr;
`ifdef AN_ERR_CNT_EN
    logic [15:0] corr_cnt;
    logic [15:0] fail_cnt;
`endif

    an_decode_ctrl_n37 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_msg    (out_msg),
        .out_err    (out_err),
        .out_uncorr (out_uncorr)
`ifdef AN_ERR_CNT_EN
        ,
        .corr_cnt   (corr_cnt),
        .fail_cnt   (fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;
    bit rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference decode from the arithmetic definition of the AN code.
    function automatic void ref_decode(input int x, output int msg, output bit err, output bit unc);
        int q, r, adj, m, p;
        q   = x / 37;
        r   = x % 37;
        adj = 0;
        for (int i = 0; i < 18; i++) begin
            p = 1 << i;
            if (r == p % 37)           adj = -(p / 37);
            else if (r == 37 - p % 37) adj = (p + 36) / 37;
        end
        m   = q + adj;
        err = (r != 0);
        if (m < 0 || m > 8191) begin unc = 1'b1; msg = 0; end
        else                   begin unc = 1'b0; msg = m; end
    endfunction

    // Cycle-level reference: an accepted word surfaces 5 cycles later and
    // is held until out_ready; the controller is busy until that handshake.
    bit m_busy = 0, m_valid = 0, m_err = 0, m_unc = 0, p_err = 0, p_unc = 0;
    int m_cnt = 0, m_msg = 0, p_msg = 0, m_corr = 0, m_fail = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_cnt = 0; m_corr = 0; m_fail = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 0;
                m_busy  = 0;
                if (m_unc)      m_fail = (m_fail == 65535) ? m_fail : m_fail + 1;
                else if (m_err) m_corr = (m_corr == 65535) ? m_corr : m_corr + 1;
            end
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1; m_msg = p_msg; m_err = p_err; m_unc = p_unc;
            end
        end else if (in_valid) begin
            m_busy = 1;
            m_cnt  = 4;
            ref_decode(int'(in_code), p_msg, p_err, p_unc);
        end
    end

    // Per-cycle comparison against the reference, away from the clock edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", in_ready, !m_busy);
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("out_msg", out_msg, m_msg);
                check("out_err", out_err, m_err);
                check("out_uncorr", out_uncorr, m_unc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input int code);
        bit acc;
        int guard;
        acc = 0; guard = 0;
        in_valid = 1'b1;
        in_code  = 19'(code);
        while (!acc && guard < 60) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat, rmsg, seen;
    bit rerr, runc;
    int  dcode [4] = '{3701, 3636, 3699, 524287};
    int  dmsg  [4] = '{100, 100, 100, 0};
    bit  derr  [4] = '{1, 1, 1, 1};
    bit  dunc  [4] = '{0, 0, 0, 1};

    initial begin
        // Pin the reference model with hand-computed values.
        ref_decode(3700, rmsg, rerr, runc);
        check("model_3700_msg", rmsg, 100);
        check("model_3700_err", rerr, 0);
        ref_decode(3636, rmsg, rerr, runc);
        check("model_3636_msg", rmsg, 100);
        ref_decode(524287, rmsg, rerr, runc);
        check("model_524287_unc", runc, 1);
        ref_decode(3700 + 262144, rmsg, rerr, runc);
        check("model_bit18_alias_msg", rmsg, 7185);

        // Reset state.
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_uncorr", out_uncorr, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Clean word: latency, single-cycle valid, in_ready return.
        out_ready = 1'b1;
        send(3700);
        wait_valid(lat);
        check("latency", lat, 5);
        check("clean_msg", out_msg, 100);
        check("clean_err", out_err, 0);
        check("clean_uncorr", out_uncorr, 0);
        tick();
        @(negedge clk);
        check("valid_one_cycle", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);

        // Single-bit errors and range failure.
        for (int k = 0; k < 4; k++) begin
            send(dcode[k]);
            wait_valid(lat);
            check("dir_msg", out_msg, dmsg[k]);
            check("dir_err", out_err, derr[k]);
            check("dir_uncorr", out_uncorr, dunc[k]);
            tick();
        end

        // Backpressure: hold 7 cycles, a second in_valid must be ignored.
        out_ready = 1'b0;
        send(3636);
        wait_valid(lat);
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_code  = 19'd3700;
            tick();
            @(negedge clk);
            check("bp_valid_held", out_valid, 1);
            check("bp_msg_held", out_msg, 100);
            check("bp_err_held", out_err, 1);
            check("bp_in_ready_low", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_released", out_valid, 0);
        seen = 0;
        repeat (8) begin tick(); @(negedge clk); if (out_valid) seen++; end
        check("bp_no_second_word", seen, 0);

        // Reset while in RED.
        send(3700);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_msg", out_msg, 0);
        seen = 0;
        repeat (10) begin tick(); @(negedge clk); if (out_valid) seen++; end
        check("midrst_no_stale", seen, 0);

        // Randomized stream with random backpressure and occasional reset.
        rand_rdy = 1'b1;
        for (int w = 0; w < 200; w++) begin
            int msg, code;
            msg = $urandom_range(0, 8191);
            case ($urandom_range(0, 3))
                0:       code = msg * 37;
                1:       code = (msg * 37) ^ (1 << $urandom_range(0, 17));
                2:       code = (msg * 37) ^ (1 << 18);
                default: code = $urandom_range(0, 524287);
            endcase
            send(code);
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
`ifdef AN_ERR_CNT_EN
        @(negedge clk);
        check("rand_corr_cnt", corr_cnt, m_corr);
        check("rand_fail_cnt", fail_cnt, m_fail);

        // Counter directed stream and saturation.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        send(3701);   wait_valid(lat); tick();
        send(524287); wait_valid(lat); tick();
        send(3700);   wait_valid(lat); tick();
        @(negedge clk);
        check("cnt_corr", corr_cnt, 1);
        check("cnt_fail", fail_cnt, 1);
        force dut.fail_cnt_q = 16'hFFFF;
        tick();
        release dut.fail_cnt_q;
        send(524287); wait_valid(lat); tick();
        repeat (2) tick();
        @(negedge clk);
        check("cnt_fail_saturated", fail_cnt, 16'hFFFF);
        check("cnt_corr_unchanged", corr_cnt, 1);
`endif
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/an_decode_ctrl_n37.md
Name: an_decode_ctrl_n37

Overview:
- Multi-cycle sequencer that turns a raw AN-coded word (A=37) into a corrected message.
- Sequences three steps: Barrett reduction (quotient/residue), single-bit-error correction from the residue, and output handshake.
- Sits between the codeword source (memory/bus read path) and the message consumer.
- Ready/valid on both sides; one codeword in flight at a time.

Parameters:
- A, 37, AN code constant (fixed; tables below are derived for 37).
- CW_W, 19, codeword width.
- MSG_W, 13, message width.
- MU, 453438, Barrett constant floor(2^24/37).
- SHIFT, 24, Barrett shift.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  codeword valid.
- in_ready  out  1  controller can accept a codeword.
- in_code  in  19  received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_msg  out  13  corrected message.
- out_err  out  1  residue was nonzero (error detected).
- out_uncorr  out  1  correction out of message range; out_msg forced to 0.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_msg=0, out_err=0, out_uncorr=0, all internal registers 0.
- Reset mid-operation aborts the in-flight word; nothing is emitted.
- FSM states: IDLE, MUL, RED, FIX, COR, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_code into x and go to MUL.
  - in_ready is low in every other state.
- MUL: p = x*MU (38-bit); register q_est = p>>24 (14 bits); go to RED.
- RED: r = x - 37*q_est (20-bit unsigned; guaranteed 0..73); go to FIX.
- FIX: if r>=37 then r-=37 and q_est+=1. At most one subtraction is ever needed for x<2^19. Go to COR.
- COR: signed adjust from 6-bit residue r:
  - r=0: adj=0.
  - r == 2^i mod 37 (i=0..17): adj = -floor(2^i/37).
  - r == 37-(2^i mod 37): adj = +ceil(2^i/37).
  - Example values: r=1→0; 27→-1; 18→-3542; 36→+1; 10→+2; 19→+3543.
  - Implement as a 37-entry constant ROM.
  - m = q_est + adj, computed in 15-bit signed.
  - Register out_err = (r!=0).
  - If m<0 or m>8191: out_uncorr=1, out_msg=0. Else out_msg=m[12:0], out_uncorr=0.
  - Assert out_valid; go to OUT.
- OUT:
  - Hold out_msg/out_err/out_uncorr stable while out_valid=1 and out_ready=0.
  - On out_ready: deassert out_valid, go to IDLE.
- Latency and throughput:
  - Accept at cycle 0 → out_valid at cycle 5. With out_ready held high, out_valid is high for exactly 1 cycle.
  - in_ready returns high the cycle after the output handshake.
  - Throughput is 1 word per 6 cycles minimum.
- Correction coverage:
  - Correction is defined for single-bit errors in bits 0..17.
  - An error in bit 18 aliases to residue 36 and is miscorrected (adj=+1). This is a known limitation; out_err is still 1.
- out_ready asserted while out_valid=0 is ignored.
- in_valid asserted outside IDLE is ignored; the source must hold the word until the in_ready handshake.

Optional Feature:
- Macro AN_ERR_CNT_EN.
- When defined, two extra outputs exist:
  - corr_cnt[15:0]: words with out_err=1 and out_uncorr=0.
  - fail_cnt[15:0]: words with out_uncorr=1.
- Both counters:
  - Increment on the output handshake (out_valid & out_ready) only.
  - Saturate at 16'hFFFF.
  - Reset to 0 on rst_n=0.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Clean word: in_code=3700, out_ready=1 → out_valid at cycle 5 with out_msg=100, out_err=0, out_uncorr=0; in_ready high again the next cycle.
- Single-bit errors on 3700:
  - 3701 (bit0 flip) → r=1 → out_msg=100, out_err=1.
  - 3636 (bit6 flip) → q=98, r=10 → out_msg=100, out_err=1.
  - 3699 → r=36 → out_msg=100, out_err=1.
- Range failure: in_code=524287 → q=14169, r=34, m=14163 → out_msg=0, out_err=1, out_uncorr=1.
- Backpressure: out_ready=0 for 7 cycles after out_valid → outputs stable and in_ready=0 throughout; a second in_valid is ignored; the result is released on the first out_ready=1.
- Reset mid-op: rst_n=0 in RED state → next cycle in_ready=1, out_valid=0, out_msg=0; no stale result appears afterwards.
- AN_ERR_CNT_EN: stream 3701, 524287, 3700 → corr_cnt=1, fail_cnt=1; force fail_cnt to 16'hFFFF, send another 524287 → stays 16'hFFFF.
